// File: rtl/alu_74382_pkg.sv
// Shared definitions for the 74382 ALU slice and its slice-serial wrapper.
// Contents:
//   SELECT_W, SLICE_W - opcode width and bits per 74382 slice
//   op_e              - 74382 function-select encoding
//   state_e           - wrapper FSM states
//   slice_res_t       - {F, Cn+4, OVR} result of one slice
//   slice_add()       - 4-bit add with carry-out and signed overflow
package alu_74382_pkg;

    localparam int SELECT_W = 3;
    localparam int SLICE_W  = 4;

    typedef enum logic [SELECT_W-1:0] {
        OP_CLEAR   = 3'd0,
        OP_B_SUB_A = 3'd1,
        OP_A_SUB_B = 3'd2,
        OP_ADD     = 3'd3,
        OP_XOR     = 3'd4,
        OP_OR      = 3'd5,
        OP_AND     = 3'd6,
        OP_PRESET  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [SLICE_W-1:0] f;
        logic               cout;
        logic               ovr;
    } slice_res_t;

    // Overflow is the carry into the MSB xor the carry out of the MSB, so a
    // chain of slices reports two's-complement overflow of the full word.
    function automatic slice_res_t slice_add(input logic [SLICE_W-1:0] x,
                                             input logic [SLICE_W-1:0] y,
                                             input logic               c);
        slice_res_t           r;
        logic [SLICE_W:0]     sum;
        logic [SLICE_W-1:0]   low;
        sum    = {1'b0, x} + {1'b0, y} + {{SLICE_W{1'b0}}, c};
        low    = {1'b0, x[SLICE_W-2:0]} + {1'b0, y[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, c};
        r.f    = sum[SLICE_W-1:0];
        r.cout = sum[SLICE_W];
        r.ovr  = low[SLICE_W-1] ^ sum[SLICE_W];
        return r;
    endfunction

endpackage

// File: rtl/alu_74382.sv
// One 4-bit 74382 ALU slice, purely combinational.
// Ports:
//   a_i, b_i  - 4-bit operands
//   s_i       - function select (op_e encoding)
//   cn_i      - carry in
//   f_o       - 4-bit function output
//   cn4_o     - carry out (arithmetic ops; 0 for logic, CLEAR, PRESET)
//   ovr_o     - signed overflow (arithmetic ops; 0 otherwise)
module alu_74382
    import alu_74382_pkg::*;
(
    input  logic [SLICE_W-1:0]  a_i,
    input  logic [SLICE_W-1:0]  b_i,
    input  logic [SELECT_W-1:0] s_i,
    input  logic                cn_i,
    output logic [SLICE_W-1:0]  f_o,
    output logic                cn4_o,
    output logic                ovr_o
);

    always_comb begin
        f_o   = '0;
        cn4_o = 1'b0;
        ovr_o = 1'b0;
        case (op_e'(s_i))
            OP_CLEAR:   f_o = '0;
            OP_B_SUB_A: {f_o, cn4_o, ovr_o} = slice_add(b_i, ~a_i, cn_i);
            OP_A_SUB_B: {f_o, cn4_o, ovr_o} = slice_add(a_i, ~b_i, cn_i);
            OP_ADD:     {f_o, cn4_o, ovr_o} = slice_add(a_i, b_i, cn_i);
            OP_XOR:     f_o = a_i ^ b_i;
            OP_OR:      f_o = a_i | b_i;
            OP_AND:     f_o = a_i & b_i;
            OP_PRESET:  f_o = '1;
            default:    f_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_74382_seq.sv
// Slice-serial wrapper around the 74382 slice: a full OPERAND_W operation is
// computed SLICES_PER_CYC slices per clock, LSB first, with the carry held in
// a register between cycles.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - request handshake (sel, port_a, port_b, carry_in)
//   out_valid / out_ready- result handshake (result, overflow, carry_out)
//   busy                 - high while slices are being evaluated
module alu_74382_seq
    import alu_74382_pkg::*;
#(
    parameter int OPERAND_W      = 16,
    parameter int SLICES_PER_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SELECT_W-1:0]  sel,
    input  logic [OPERAND_W-1:0] port_a,
    input  logic [OPERAND_W-1:0] port_b,
    input  logic                 carry_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPERAND_W-1:0] result,
    output logic                 overflow,
    output logic                 carry_out,
    output logic                 busy
);

    localparam int N     = OPERAND_W / SLICE_W;
    localparam int STEPS = (SLICES_PER_CYC > 0) ? N / SLICES_PER_CYC : 1;
    localparam int WIN   = SLICE_W * SLICES_PER_CYC;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int IDX_W = (OPERAND_W > 1) ? $clog2(OPERAND_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    if ((OPERAND_W % SLICE_W) != 0 || OPERAND_W < SLICE_W) begin : g_bad_width
        $error("alu_74382_seq: OPERAND_W must be a multiple of 4 and at least 4");
    end
    if (SLICES_PER_CYC < 1 || (N % SLICES_PER_CYC) != 0) begin : g_bad_slices
        $error("alu_74382_seq: SLICES_PER_CYC must divide OPERAND_W/4");
    end

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  carry_q;
    logic [SELECT_W-1:0]   sel_q;
    logic [OPERAND_W-1:0]  a_q;
    logic [OPERAND_W-1:0]  b_q;
    logic [OPERAND_W-1:0]  result_q;
    logic                  ovr_q;
    logic                  cout_q;
    logic                  out_valid_q;
    logic                  busy_q;

    logic                  accept;
    logic [IDX_W-1:0]      base;
    logic [WIN-1:0]        a_win;
    logic [WIN-1:0]        b_win;
    logic [WIN-1:0]        f_d;
    logic [SLICES_PER_CYC:0] chain_c;
    logic                  ovr_last;
    logic                  carry_d;

    // in_ready is held low while reset is asserted even though the state is IDLE.
    assign in_ready = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // Bit offset of the slice group handled this cycle.
    assign base  = IDX_W'(cnt_q) * IDX_W'(WIN);
    assign a_win = a_q[base +: WIN];
    assign b_win = b_q[base +: WIN];

    // carry_q holds the latched carry_in for the first group, then the
    // carry out of the previous group.
    assign chain_c[0] = carry_q;
    assign carry_d    = chain_c[SLICES_PER_CYC];

    for (genvar g = 0; g < SLICES_PER_CYC; g++) begin : g_slice
        if (g == SLICES_PER_CYC - 1) begin : g_last
            alu_74382 u_slice (
                .a_i   (a_win[g*SLICE_W +: SLICE_W]),
                .b_i   (b_win[g*SLICE_W +: SLICE_W]),
                .s_i   (sel_q),
                .cn_i  (chain_c[g]),
                .f_o   (f_d[g*SLICE_W +: SLICE_W]),
                .cn4_o (chain_c[g+1]),
                .ovr_o (ovr_last)
            );
        end else begin : g_inner
            logic ovr_inner_unused;
            alu_74382 u_slice (
                .a_i   (a_win[g*SLICE_W +: SLICE_W]),
                .b_i   (b_win[g*SLICE_W +: SLICE_W]),
                .s_i   (sel_q),
                .cn_i  (chain_c[g]),
                .f_o   (f_d[g*SLICE_W +: SLICE_W]),
                .cn4_o (chain_c[g+1]),
                .ovr_o (ovr_inner_unused)
            );
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sel_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            ovr_q       <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            // Also covers DONE with out_ready: the next request starts with no IDLE bubble.
            sel_q       <= sel;
            a_q         <= port_a;
            b_q         <= port_b;
            carry_q     <= carry_in;
            cnt_q       <= '0;
            state_q     <= ST_BUSY;
            busy_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BUSY: begin
                    result_q[base +: WIN] <= f_d;
                    carry_q               <= carry_d;
                    if (cnt_q == CNT_LAST) begin
                        cout_q      <= carry_d;
                        ovr_q       <= ovr_last;
                        state_q     <= ST_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;
    assign overflow  = ovr_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_alu_74382_seq.sv
module tb_alu_74382_seq;
    import alu_74382_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Full-width reference: arithmetic done on the whole word, not by slices.
    function automatic exp_t model(input int w, input logic [2:0] s, input logic [31:0] a,
                                   input logic [31:0] b, input logic c);
        exp_t        e;
        logic [31:0] mask;
        logic [31:0] x;
        logic [31:0] y;
        logic [32:0] sum;
        logic        arith;
        mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        e.res = '0;
        e.co  = 1'b0;
        e.ov  = 1'b0;
        arith = 1'b0;
        x     = '0;
        y     = '0;
        case (s)
            3'd1: begin x = b; y = ~a & mask; arith = 1'b1; end
            3'd2: begin x = a; y = ~b & mask; arith = 1'b1; end
            3'd3: begin x = a; y = b;         arith = 1'b1; end
            3'd4: e.res = a ^ b;
            3'd5: e.res = a | b;
            3'd6: e.res = a & b;
            3'd7: e.res = mask;
            default: e.res = '0;
        endcase
        if (arith) begin
            sum   = {1'b0, x} + {1'b0, y} + {32'b0, c};
            e.res = sum[31:0] & mask;
            e.co  = sum[w];
            e.ov  = (x[w-1] == y[w-1]) && (e.res[w-1] != x[w-1]);
        end
        return e;
    endfunction

    // ---------------- directed DUT: 16 bits, one slice per cycle ----------------
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sel;
    logic [15:0] port_a;
    logic [15:0] port_b;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        overflow;
    logic        carry_out;
    logic        busy;

    exp_t exp_q[$];

    alu_74382_seq #(.OPERAND_W(16), .SLICES_PER_CYC(1)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .port_a    (port_a),
        .port_b    (port_b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .carry_out (carry_out),
        .busy      (busy)
    );

    task automatic issue(input logic [2:0] s_v, input logic [15:0] a_v, input logic [15:0] b_v,
                         input logic c_v, input exp_t e);
        @(negedge clk);
        sel      = s_v;
        port_a   = a_v;
        port_b   = b_v;
        carry_in = c_v;
        in_valid = 1'b1;
        exp_q.push_back(e);
        #1;
        check("in_ready_at_accept", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        // Scramble inputs so a design that re-samples them mid-operation is caught.
        in_valid = 1'b0;
        port_a   = 16'($urandom);
        port_b   = 16'($urandom);
        carry_in = ~carry_in;
        sel      = 3'($urandom);
        check("busy_after_accept", 64'(busy), 64'(1));
        check("ov_low_after_accept", 64'(out_valid), 64'(0));
    endtask

    task automatic wait_result(input string tag, output exp_t e);
        int lat;
        lat = 0;
        e   = '{32'h0, 1'b0, 1'b0};
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(4));
        check({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_result"}, 64'(result), 64'(e.res[15:0]));
            check({tag, "_carry_out"}, 64'(carry_out), 64'(e.co));
            check({tag, "_overflow"}, 64'(overflow), 64'(e.ov));
        end
    endtask

    // ---------------- random configurations ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_rnd
        localparam int W   = (gi == 2) ? 32 : 16;
        localparam int P   = (gi == 0) ? 1 : ((gi == 1) ? 4 : 2);
        localparam int LAT = W / 4 / P;

        logic         rrst_n;
        logic         riv;
        logic         rir;
        logic [2:0]   rsel;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rci;
        logic         rov;
        logic         rrdy;
        logic [W-1:0] rres;
        logic         rovf;
        logic         rco;
        logic         rbsy;
        exp_t         rq[$];

        alu_74382_seq #(.OPERAND_W(W), .SLICES_PER_CYC(P)) u_dut (
            .clk       (clk),
            .rst_n     (rrst_n),
            .in_valid  (riv),
            .in_ready  (rir),
            .sel       (rsel),
            .port_a    (ra),
            .port_b    (rb),
            .carry_in  (rci),
            .out_valid (rov),
            .out_ready (rrdy),
            .result    (rres),
            .overflow  (rovf),
            .carry_out (rco),
            .busy      (rbsy)
        );

        initial begin
            exp_t e;
            int   lat;
            int   stall;
            rrst_n = 1'b0;
            riv    = 1'b0;
            rrdy   = 1'b0;
            rsel   = '0;
            ra     = '0;
            rb     = '0;
            rci    = 1'b0;
            repeat (2) @(negedge clk);
            rrst_n = 1'b1;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                rsel = 3'($urandom);
                ra   = W'($urandom);
                rb   = W'($urandom);
                rci  = 1'($urandom);
                riv  = 1'b1;
                rrdy = 1'b1;
                rq.push_back(model(W, rsel, 32'(ra), 32'(rb), rci));
                #1;
                check("rnd_in_ready", 64'(rir), 64'(1));
                @(posedge clk);
                #1;
                riv  = 1'b0;
                ra   = W'($urandom);
                rb   = W'($urandom);
                rsel = 3'($urandom);
                lat  = 0;
                while (!rov && lat < 200) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                rrdy = 1'b0;
                check("rnd_latency", 64'(lat), 64'(LAT));
                e = rq.pop_front();
                check("rnd_result", 64'(rres), 64'(e.res[W-1:0]));
                check("rnd_carry_out", 64'(rco), 64'(e.co));
                check("rnd_overflow", 64'(rovf), 64'(e.ov));
                stall = $urandom_range(0, 2);
                repeat (stall) begin
                    @(posedge clk);
                    #1;
                    check("rnd_hold_valid", 64'(rov), 64'(1));
                    check("rnd_hold_result", 64'(rres), 64'(e.res[W-1:0]));
                end
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    rrdy = 1'b1;
                    @(posedge clk);
                    #1;
                    rrdy = 1'b0;
                    check("rnd_idle_ov_drop", 64'(rov), 64'(0));
                end
            end
            done_cnt++;
        end
    end

    // ---------------- directed sequence ----------------
    logic [2:0]  lg_sel [5];
    logic [15:0] lg_a   [5];
    logic [15:0] lg_b   [5];
    logic        lg_c   [5];

    initial begin
        exp_t e;
        int   seen;
        int   guard;
        lg_sel = '{3'd4, 3'd5, 3'd6, 3'd0, 3'd7};
        lg_a   = '{16'hA5A5, 16'h1200, 16'hF0F0, 16'h1234, 16'h0000};
        lg_b   = '{16'h0FF0, 16'h0034, 16'h3C3C, 16'hFFFF, 16'h0000};
        lg_c   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sel       = '0;
        port_a    = '0;
        port_b    = '0;
        carry_in  = 1'b0;
        #3;
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_carry_out", 64'(carry_out), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));

        out_ready = 1'b1;
        issue(3'(OP_ADD), 16'h1234, 16'h0FFF, 1'b0, '{32'h2233, 1'b0, 1'b0});
        wait_result("add_basic", e);
        @(posedge clk);
        #1;
        check("idle_ov_drop", 64'(out_valid), 64'(0));
        check("idle_in_ready", 64'(in_ready), 64'(1));
        check("idle_result_kept", 64'(result), 64'(16'h2233));

        issue(3'(OP_ADD), 16'hFFFF, 16'h0001, 1'b0, '{32'h0000, 1'b1, 1'b0});
        wait_result("add_wrap", e);
        issue(3'(OP_ADD), 16'h7FFF, 16'h0001, 1'b0, '{32'h8000, 1'b0, 1'b1});
        wait_result("add_ovf", e);
        issue(3'(OP_A_SUB_B), 16'h0005, 16'h0003, 1'b1, '{32'h0002, 1'b1, 1'b0});
        wait_result("a_sub_b", e);
        issue(3'(OP_B_SUB_A), 16'h0005, 16'h0003, 1'b1, '{32'hFFFE, 1'b0, 1'b0});
        wait_result("b_sub_a", e);
        for (int i = 0; i < 5; i++) begin
            issue(lg_sel[i], lg_a[i], lg_b[i], lg_c[i], model(16, lg_sel[i], 32'(lg_a[i]), 32'(lg_b[i]), lg_c[i]));
            wait_result($sformatf("logic_op%0d", i), e);
        end

        // Result held in DONE under backpressure, then back-to-back accept.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(3'(OP_ADD), 16'h00FF, 16'h0F01, 1'b0, '{32'h1000, 1'b0, 1'b0});
        wait_result("stall", e);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_result", 64'(result), 64'(16'h1000));
            check("stall_carry_out", 64'(carry_out), 64'(0));
            check("stall_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        issue(3'(OP_XOR), 16'hFFFF, 16'h00FF, 1'b0, '{32'hFF00, 1'b0, 1'b0});
        wait_result("back_to_back", e);

        // Reset on the second BUSY cycle discards the operation.
        @(posedge clk);
        #1;
        issue(3'(OP_ADD), 16'h1111, 16'h2222, 1'b0, '{32'h3333, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(0));
        check("midrst_result", 64'(result), 64'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_release_in_ready", 64'(in_ready), 64'(1));
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_stale_valid", 64'(seen), 64'(0));

        guard = 0;
        while (done_cnt < 3 && guard < 60000) begin
            @(posedge clk);
            guard++;
        end
        check("random_configs_done", 64'(done_cnt), 64'(3));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
